if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage.
- Holds the PC, drives the instruction-memory request, and selects the next PC from decode's pcsource/bpc/jpc/register target.
- Contains the IF/ID pipeline register that delivers dpc4 and inst to decode.
- Honours decode's nostall interlock and inserts NOP bubbles while instruction memory is not ready.

---
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
//==============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Holds the PC, drives the instruction
//               memory request, selects the next PC from decode's pcsource
//               (pc+4 / bpc / ra / jpc) and owns the IF/ID register that
//               delivers dpc4 and inst to decode. Inserts NOP bubbles while
//               instruction memory is not ready and honours decode's nostall.
//               Optional performance counters: define IF_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        redir_pend,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    localparam logic [1:0] c_SRC_PC4 = 2'b00;
    localparam logic [1:0] c_SRC_BPC = 2'b01;
    localparam logic [1:0] c_SRC_RA  = 2'b10;
    localparam logic [1:0] c_SRC_JPC = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] r_dpc4;
    logic [31:0] r_inst;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc4;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_fetch_done;
    logic        w_fetch_wait;

    // pc+4 wraps naturally at 2^32
    assign w_pc4        = r_pc + 32'd4;
    assign w_redirect   = nostall && (pcsource != c_SRC_PC4);
    assign w_fetch_done = nostall && imem_ready;
    assign w_fetch_wait = nostall && !imem_ready;

    // Redirect target selected by decode's pcsource
    always_comb begin
        w_target = w_pc4;
        case (pcsource)
            c_SRC_BPC: w_target = bpc;
            c_SRC_RA:  w_target = ra;
            c_SRC_JPC: w_target = jpc;
            default:   w_target = w_pc4;
        endcase
    end

    // PC, IF/ID register and pending-redirect bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_dpc4       <= 32'd0;
            r_inst       <= NOP_INST;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'd0;
        end else if (w_fetch_done) begin
            // Delay-slot instruction is always delivered; no flush
            r_dpc4 <= w_pc4;
            r_inst <= imem_rdata;
            if (r_redir_pend) begin
                r_pc         <= r_redir_pc;
                r_redir_pend <= 1'b0;
            end else if (w_redirect) begin
                r_pc <= w_target;
            end else begin
                r_pc <= w_pc4;
            end
        end else if (w_fetch_wait) begin
            // Bubble to decode; PC holds and re-requests the same address
            r_inst <= NOP_INST;
            r_dpc4 <= w_pc4;
            // An already-pending target wins over a late redirect
            if (w_redirect && !r_redir_pend) begin
                r_redir_pc   <= w_target;
                r_redir_pend <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Count delivered fetches and inserted bubbles (wrap at 2^32)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_fetch_done) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (w_fetch_wait) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign fetch_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

    // Request is live whenever reset is released
    assign imem_req   = !rst;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign dpc4       = r_dpc4;
    assign inst       = r_inst;
    assign redir_pend = r_redir_pend;

    // Decode must not issue a new redirect while one is pending
    a_no_redir_while_pend : assert property (
        @(posedge clk) disable iff (rst) !(r_redir_pend && w_redirect)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] ra;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] inst;
    logic        redir_pend;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int checks;
    int failures;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .nostall    (nostall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .redir_pend (redir_pend),
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // Instruction memory: word content is a fixed function of its address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_fetch;
        logic [31:0] exp_bubble;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        nostall    = 1'b1;
        pcsource   = 2'b00;
        bpc        = 32'd0;
        jpc        = 32'd0;
        ra         = 32'd0;
        imem_ready = 1'b1;

        // Reset held 3 cycles with memory ready
        repeat (3) tick();
        check("rst_pc",     pc,         32'h0);
        check("rst_inst",   inst,       32'h0);
        check("rst_dpc4",   dpc4,       32'h0);
        check("rst_req",    {31'd0, imem_req},   32'h0);
        check("rst_pend",   {31'd0, redir_pend}, 32'h0);
        check("rst_fcnt",   fetch_cnt,  32'h0);
        check("rst_bcnt",   bubble_cnt, 32'h0);

        // Sequential fetch after release
        rst = 1'b0;
        #1;
        check("rel_addr", imem_addr, 32'h0);
        check("rel_req",  {31'd0, imem_req}, 32'h1);
        tick();
        check("seq1_pc",   pc,   32'h4);
        check("seq1_dpc4", dpc4, 32'h4);
        check("seq1_inst", inst, mem(32'h0));
        tick();
        check("seq2_addr", imem_addr, 32'h8);
        check("seq2_dpc4", dpc4, 32'h8);
        tick();
        check("seq3_dpc4", dpc4, 32'hC);
        tick();
        check("seq4_pc",   pc,   32'h10);
        check("seq4_inst", inst, mem(32'hC));

        // Stall two cycles at pc=0x10
        nostall = 1'b0;
        pcsource = 2'b01;
        bpc = 32'h0000_0BAD;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pc",   pc,   32'h10);
            check("stall_dpc4", dpc4, 32'h10);
            check("stall_inst", inst, mem(32'hC));
        end
        nostall = 1'b1;
        pcsource = 2'b00;
        tick();
        check("unstall_pc",   pc,   32'h14);
        check("unstall_dpc4", dpc4, 32'h14);
        check("unstall_inst", inst, mem(32'h10));

        // Jump to 0x20, then branch with zero-wait memory
        pcsource = 2'b11;
        jpc = 32'h20;
        tick();
        check("j20_pc", pc, 32'h20);
        pcsource = 2'b01;
        bpc = 32'h100;
        tick();
        check("br_inst", inst, mem(32'h20));
        check("br_dpc4", dpc4, 32'h24);
        check("br_pc",   pc,   32'h100);
        pcsource = 2'b00;
        tick();
        check("br_next_pc",   pc,   32'h104);
        check("br_next_inst", inst, mem(32'h100));

        // Back to 0x20, then jump with two wait cycles
        pcsource = 2'b11;
        jpc = 32'h20;
        tick();
        check("j20b_pc", pc, 32'h20);
        jpc = 32'h400;
        imem_ready = 1'b0;
        tick();
        check("w1_inst", inst, 32'h0);
        check("w1_pend", {31'd0, redir_pend}, 32'h1);
        check("w1_pc",   pc,   32'h20);
        check("w1_dpc4", dpc4, 32'h24);
        pcsource = 2'b00;
        tick();
        check("w2_inst", inst, 32'h0);
        check("w2_pend", {31'd0, redir_pend}, 32'h1);
        check("w2_pc",   pc,   32'h20);
        imem_ready = 1'b1;
        tick();
        check("wdone_inst", inst, mem(32'h20));
        check("wdone_dpc4", dpc4, 32'h24);
        check("wdone_pc",   pc,   32'h400);
        check("wdone_pend", {31'd0, redir_pend}, 32'h0);

        // jr to the top word, then wrap to 0
        pcsource = 2'b10;
        ra = 32'hFFFF_FFFC;
        tick();
        check("jr_pc",   pc,   32'hFFFF_FFFC);
        check("jr_dpc4", dpc4, 32'h404);
        pcsource = 2'b00;
        tick();
        check("wrap_pc",   pc,   32'h0);
        check("wrap_dpc4", dpc4, 32'h0);
        check("wrap_inst", inst, mem(32'hFFFF_FFFC));

`ifdef IF_PERF_CNT_EN
        exp_fetch  = 32'd12;
        exp_bubble = 32'd2;
`else
        exp_fetch  = 32'd0;
        exp_bubble = 32'd0;
`endif
        check("cnt1_fetch",  fetch_cnt,  exp_fetch);
        check("cnt1_bubble", bubble_cnt, exp_bubble);

        // Reset asserted mid-wait with a pending redirect
        pcsource = 2'b01;
        bpc = 32'h800;
        imem_ready = 1'b0;
        tick();
        check("mid_pend", {31'd0, redir_pend}, 32'h1);
        pcsource = 2'b00;
        rst = 1'b1;
        #1;
        check("async_pend", {31'd0, redir_pend}, 32'h0);
        check("async_pc",   pc, 32'h0);
        check("async_req",  {31'd0, imem_req}, 32'h0);
        check("async_fcnt", fetch_cnt, 32'h0);
        tick();
        rst = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("post_pc",   pc,   32'h4);
        check("post_inst", inst, mem(32'h0));

        // Four more fetches (five total) and two waits
        repeat (4) tick();
        imem_ready = 1'b0;
        repeat (2) tick();
        check("post_hold_pc", pc, 32'h14);
`ifdef IF_PERF_CNT_EN
        exp_fetch  = 32'd5;
        exp_bubble = 32'd2;
`else
        exp_fetch  = 32'd0;
        exp_bubble = 32'd0;
`endif
        check("cnt2_fetch",  fetch_cnt,  exp_fetch);
        check("cnt2_bubble", bubble_cnt, exp_bubble);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
